asansor_ctrl: RTL and testbench

ASANSOR_CTRL -- requirements
Module: asansor_ctrl

---
 rtl/asansor_pkg.sv | 25 ++
 rtl/asansor_timer.sv | 28 ++
 rtl/asansor_ctrl.sv | 156 +++++++++++++++
 tb/tb_asansor_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/asansor_pkg.sv
// Shared types and constants for the two-floor elevator controller.
package asansor_pkg;

    localparam int unsigned BTN_W   = 2;
    localparam int unsigned LED_W   = 2;
    localparam int unsigned TIMER_W = 8;

    localparam int unsigned DEF_TRAVEL_CYCLES = 4;
    localparam int unsigned DEF_DOOR_CYCLES   = 3;

    localparam logic FLOOR_0 = 1'b0;
    localparam logic FLOOR_1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    // One-hot floor indicator pattern for a given floor.
    function automatic logic [LED_W-1:0] floor_led(input logic floor);
        return (floor == FLOOR_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/asansor_timer.sv
// Loadable 8-bit down-counter shared by travel and door timing.
module asansor_timer
    import asansor_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero_c
);

    logic [TIMER_W-1:0] count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/asansor_ctrl.sv
// Two-floor elevator controller: pending-call register, IDLE/MOVE/DOOR FSM,
// registered floor indicator. Optional macro ASANSOR_BTN_SYNC_EN inserts a
// two-flop synchronizer on the call buttons (two extra cycles of latency).
module asansor_ctrl
    import asansor_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BTN_W-1:0] i_btn,
    output logic [LED_W-1:0] o_led
);

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    state_t             state;
    logic               floor;
    logic [BTN_W-1:0]   pend;
    logic [BTN_W-1:0]   pend_nxt;
    logic [BTN_W-1:0]   btn;

    logic               ev_open;
    logic               ev_depart;
    logic               ev_arrive;
    logic               ev_reload;
    logic               ev_close;

    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero_c;
    logic [TIMER_W-1:0] tmr_load_val;

`ifdef ASANSOR_BTN_SYNC_EN
    logic [BTN_W-1:0] btn_meta;
    logic [BTN_W-1:0] btn_sync;

    // Two-flop synchronizer for the asynchronous call buttons.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
        end
    end

    assign btn = btn_sync;
`else
    assign btn = i_btn;
`endif

    // Decide this cycle's transition event; IDLE acts on registered calls only.
    always_comb begin
        ev_open   = 1'b0;
        ev_depart = 1'b0;
        ev_arrive = 1'b0;
        ev_reload = 1'b0;
        ev_close  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                // Current floor wins over the other floor when both are pending.
                if (pend[floor]) begin
                    ev_open = 1'b1;
                end else if (pend[~floor]) begin
                    ev_depart = 1'b1;
                end
            end
            MOVE: begin
                if (tmr_zero_c) begin
                    ev_arrive = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR: begin
                // A call for this floor keeps the door open instead of queuing.
                if (btn[floor]) begin
                    ev_reload = 1'b1;
                end else if (tmr_zero_c) begin
                    ev_close = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Timer control: every door opening or hold reloads the door time.
    assign tmr_load     = ev_open | ev_reload | ev_arrive | ev_depart;
    assign tmr_load_val = ev_depart ? TRAVEL_LOAD : DOOR_LOAD;

    // Latch new calls, then clear the call being served at this edge.
    always_comb begin
        pend_nxt = pend | btn;
        if (ev_open || ev_reload) begin
            pend_nxt[floor] = 1'b0;
        end
        if (ev_arrive) begin
            pend_nxt[~floor] = 1'b0;
        end
    end

    // State, floor, pending calls and indicator register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
            floor <= FLOOR_0;
            pend  <= '0;
            o_led <= floor_led(FLOOR_0);
        end else begin
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (ev_open) begin
                        state <= DOOR;
                    end else if (ev_depart) begin
                        state <= MOVE;
                        o_led <= '0;
                    end
                end
                MOVE: begin
                    if (ev_arrive) begin
                        state <= DOOR;
                        floor <= ~floor;
                        o_led <= floor_led(~floor);
                    end
                end
                DOOR: begin
                    if (ev_close) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_led <= floor_led(floor);
                end
            endcase
        end
    end

    asansor_timer u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero_c)
    );

endmodule

// File: tb/tb_asansor_ctrl.sv
// Bench for asansor_ctrl: cycle table with a scoreboard, then random calls.
module tb_asansor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] led;

    asansor_ctrl #(
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_btn (btn),
        .o_led (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] btn;
        logic [1:0] led;
        string      tag;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] outst    = 2'b00;

    function automatic void add(input logic r, input logic [1:0] b,
                                input logic [1:0] l, input int reps,
                                input string tag);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.led = l;
        v.tag = tag;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endfunction

    function automatic logic [1:0] onehot_of(input int k);
        return (k == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic check_led(input logic [1:0] exp, input string tag);
        n_checks++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: o_led=%b expected %b at %0t", tag, led, exp, $time);
        end
    endtask

    // Random phase: indicator never 11, and every press later sees its floor lit.
    task automatic observe(input logic [1:0] pressed);
        n_checks++;
        if ($isunknown(led) || led == 2'b11) begin
            n_fail++;
            $display("FAIL led_legal: o_led=%b expected one-hot or 00 at %0t", led, $time);
        end
        for (int k = 0; k < 2; k++) begin
            if (outst[k] && led == onehot_of(k)) outst[k] = 1'b0;
        end
        outst = outst | pressed;
    endtask

    initial begin
        logic [1:0] exp;
        logic [1:0] r;

        rst = 1'b0;
        btn = 2'b00;

        // Reset and idle hold
        add(1'b0, 2'b00, 2'b01, 1, "rst");
        add(1'b0, 2'b10, 2'b01, 1, "rst_btn_ignored");
        add(1'b1, 2'b00, 2'b01, 3, "idle_hold");
        // Single call to floor 1
        add(1'b1, 2'b10, 2'b01, 1, "call_f1");
        add(1'b1, 2'b00, 2'b00, 4, "move_up");
        add(1'b1, 2'b00, 2'b10, 5, "door_f1");
        // Call for departed floor during a move stays pending
        add(1'b1, 2'b01, 2'b10, 1, "call_f0");
        add(1'b1, 2'b00, 2'b00, 1, "move_dn");
        add(1'b1, 2'b10, 2'b00, 1, "call_departed");
        add(1'b1, 2'b00, 2'b00, 2, "move_dn");
        add(1'b1, 2'b00, 2'b01, 4, "door_f0");
        add(1'b1, 2'b00, 2'b00, 4, "return_up");
        add(1'b1, 2'b00, 2'b10, 5, "door_f1_again");
        // Call for destination during a move is absorbed at arrival
        add(1'b1, 2'b01, 2'b10, 1, "call_f0");
        add(1'b1, 2'b00, 2'b00, 1, "move_dn");
        add(1'b1, 2'b01, 2'b00, 1, "call_dest");
        add(1'b1, 2'b00, 2'b00, 2, "move_dn");
        add(1'b1, 2'b00, 2'b01, 5, "absorbed");
        // Both calls held: current floor door held open, then move
        add(1'b1, 2'b11, 2'b01, 10, "both_held");
        add(1'b1, 2'b00, 2'b01, 3, "door_release");
        add(1'b1, 2'b00, 2'b00, 4, "serve_f1");
        add(1'b1, 2'b00, 2'b10, 5, "arrive_f1");
        // Reset in the middle of a move discards pending calls
        add(1'b1, 2'b01, 2'b10, 1, "call_f0");
        add(1'b1, 2'b10, 2'b00, 1, "departed_pend");
        add(1'b1, 2'b00, 2'b00, 1, "move");
        add(1'b0, 2'b00, 2'b01, 1, "rst_mid_move");
        add(1'b1, 2'b00, 2'b01, 3, "pend_discarded");
        // Reset during a door stop, button ignored while in reset
        add(1'b1, 2'b10, 2'b01, 1, "call_f1");
        add(1'b1, 2'b00, 2'b00, 4, "move_up");
        add(1'b1, 2'b00, 2'b10, 1, "arrive");
        add(1'b0, 2'b10, 2'b01, 1, "rst_mid_door");
        add(1'b1, 2'b00, 2'b01, 2, "idle_after_rst");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            btn = vecs[i].btn;
            sb.push_back(vecs[i].led);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: queue empty, expected an entry at step %0d", i);
            end else begin
                exp = sb.pop_front();
                check_led(exp, $sformatf("%s[%0d]", vecs[i].tag, i));
            end
        end

        // Random calls, each value held for two cycles
        for (int c = 0; c < 10; c++) begin
            r = 2'($urandom_range(0, 3));
            for (int h = 0; h < 2; h++) begin
                @(negedge clk);
                rst = 1'b1;
                btn = r;
                @(posedge clk);
                #1;
                observe(r);
            end
        end
        for (int d = 0; d < 40; d++) begin
            @(negedge clk);
            btn = 2'b00;
            @(posedge clk);
            #1;
            observe(2'b00);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (outst[k]) begin
                n_fail++;
                $display("FAIL served_f%0d: call outstanding=1 expected 0 after drain", k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
